// File: rtl/eth_frame_tx_if.sv
// eth_frame_tx_if: header handshake, payload byte stream and outgoing frame stream of eth_frame_tx.
interface eth_frame_tx_if;
  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    output s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    output s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_axis_tready,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
    input  s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
    input  s_eth_payload_axis_tlast, s_eth_payload_axis_tuser, m_axis_tready,
    output s_eth_hdr_ready, s_eth_payload_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
  );
endinterface

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: prepends a 14-byte Ethernet header to a payload byte stream,
// truncating (tlast+tuser) and dropping the rest of frames longer than MAX_FRAME_LEN.
module eth_frame_tx #(
  parameter int MAX_FRAME_LEN = 1514
) (
  input  logic          tx_clk,
  input  logic          tx_rst,
  eth_frame_tx_if.slave bus,
  output logic          busy_o,
  output logic          error_oversize_o
);
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DROP} state_t;
  state_t        state_q, state_d;
  logic          hdr_ready_q;
  logic [111:0]  hdr_q;
  logic [111:0]  hdr_sh;
  logic [3:0]    hdr_cnt_q, hdr_cnt_d;
  logic [15:0]   byte_cnt_q, byte_cnt_d;
  logic          busy_q, busy_d, err_q;
  logic          hdr_acc, at_max, xfer_last;
  logic          ld, ld_last, ld_user, oversize, pay_ready;
  logic [7:0]    ld_data;
  logic          in_rdy_q, in_rdy_d;
  logic [7:0]    out_data_q, tmp_data_q;
  logic          out_valid_q, out_last_q, out_user_q;
  logic          tmp_valid_q, tmp_last_q, tmp_user_q;
  assign hdr_acc   = bus.s_eth_hdr_valid & hdr_ready_q;
  assign hdr_sh    = hdr_q << {hdr_cnt_q, 3'b000};
  assign at_max    = byte_cnt_q == 16'(MAX_FRAME_LEN - 1);
  assign xfer_last = out_valid_q & bus.m_axis_tready & out_last_q;
  assign busy_d    = hdr_acc | (busy_q & ~(xfer_last & (state_q == IDLE || state_q == DROP)));
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      hdr_ready_q <= 1'b0;
      hdr_q       <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      hdr_ready_q <= state_d == IDLE;
      busy_q      <= busy_d;
      err_q       <= oversize;
      if (hdr_acc) hdr_q <= {bus.s_eth_dest_mac, bus.s_eth_src_mac, bus.s_eth_type};
    end
  end
  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    byte_cnt_d = byte_cnt_q + 16'(ld);
    case (state_q)
      IDLE: if (hdr_acc) begin
        state_d    = HEADER;
        hdr_cnt_d  = 4'(ld);
        byte_cnt_d = 16'(ld);
      end
      HEADER: if (ld) begin
        hdr_cnt_d = hdr_cnt_q + 4'd1;
        state_d   = hdr_cnt_q == 4'd13 ? PAYLOAD : HEADER;
      end
      PAYLOAD: if (ld) state_d = oversize ? DROP : bus.s_eth_payload_axis_tlast ? IDLE : PAYLOAD;
      DROP: if (bus.s_eth_payload_axis_tvalid & bus.s_eth_payload_axis_tlast) state_d = IDLE;
    endcase
  end
  // The first header byte is taken straight from the bus on accept so it appears one cycle later.
  always_comb begin
    ld        = 1'b0;
    ld_data   = hdr_sh[111:104];
    ld_last   = 1'b0;
    ld_user   = 1'b0;
    oversize  = 1'b0;
    pay_ready = 1'b0;
    case (state_q)
      IDLE: begin
        ld      = hdr_acc & in_rdy_q;
        ld_data = bus.s_eth_dest_mac[47:40];
      end
      HEADER: ld = in_rdy_q;
      PAYLOAD: begin
        pay_ready = in_rdy_q;
        ld        = bus.s_eth_payload_axis_tvalid & in_rdy_q;
        ld_data   = bus.s_eth_payload_axis_tdata;
        oversize  = ld & at_max & ~bus.s_eth_payload_axis_tlast;
        ld_last   = bus.s_eth_payload_axis_tlast | oversize;
        ld_user   = bus.s_eth_payload_axis_tuser | oversize;
      end
      DROP: pay_ready = 1'b1;
    endcase
  end
  // Registered upstream ready: the temp register absorbs the one byte that may arrive after a stall.
  assign in_rdy_d = bus.m_axis_tready | (~tmp_valid_q & (~out_valid_q | ~ld));
  always_ff @(posedge tx_clk or posedge tx_rst) begin
    if (tx_rst) begin
      in_rdy_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_user_q  <= 1'b0;
      tmp_data_q  <= '0;
      tmp_valid_q <= 1'b0;
      tmp_last_q  <= 1'b0;
      tmp_user_q  <= 1'b0;
    end else begin
      in_rdy_q <= in_rdy_d;
      if (in_rdy_q) begin
        if (bus.m_axis_tready | ~out_valid_q) begin
          out_data_q  <= ld_data;
          out_valid_q <= ld;
          out_last_q  <= ld & ld_last;
          out_user_q  <= ld & ld_user;
        end else if (ld) begin
          tmp_data_q  <= ld_data;
          tmp_valid_q <= 1'b1;
          tmp_last_q  <= ld_last;
          tmp_user_q  <= ld_user;
        end
      end else if (bus.m_axis_tready) begin
        out_data_q  <= tmp_data_q;
        out_valid_q <= tmp_valid_q;
        out_last_q  <= tmp_last_q;
        out_user_q  <= tmp_user_q;
        tmp_valid_q <= 1'b0;
      end
    end
  end
  assign bus.s_eth_hdr_ready           = hdr_ready_q;
  assign bus.s_eth_payload_axis_tready = pay_ready;
  assign bus.m_axis_tdata              = out_data_q;
  assign bus.m_axis_tvalid             = out_valid_q;
  assign bus.m_axis_tlast              = out_last_q;
  assign bus.m_axis_tuser              = out_user_q;
  assign busy_o                        = busy_q;
  assign error_oversize_o              = err_q;
endmodule

// File: doc/eth_frame_tx.md
ETH_FRAME_TX -- requirements
Module: eth_frame_tx

Interface
REQ-001 SHALL: parameter MAX_FRAME_LEN, default 1514, maximum emitted bytes per frame (header + payload, no FCS); legal range 15..65535.
REQ-002 SHALL: tx_clk  in  1  clock; all logic rising-edge.
REQ-003 SHALL: tx_rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL: s_eth_hdr_valid / s_eth_hdr_ready  in / out  1 / 1  header handshake.
REQ-005 SHALL: s_eth_dest_mac  in  48  destination MAC.
REQ-006 SHALL: s_eth_src_mac  in  48  source MAC.
REQ-007 SHALL: s_eth_type  in  16  EtherType.
REQ-008 SHALL: s_eth_payload_axis_tdata/tvalid/tready/tlast/tuser  in/in/out/in/in  8/1/1/1/1  payload byte stream.
REQ-009 SHALL: m_axis_tdata/tvalid/tready/tlast/tuser  out/out/in/out/out  8/1/1/1/1  frame byte stream to MAC TX path.
REQ-010 SHALL: busy  out  1  high from header accept until the last frame byte transfers on m_axis.
REQ-011 SHALL: error_oversize  out  1  single-cycle pulse on truncation.

Function
REQ-012 SHALL: FSM states IDLE, HEADER, PAYLOAD, DROP.
REQ-013 SHALL: s_eth_hdr_ready be registered, high only in IDLE; header fields latched on hdr_valid & hdr_ready; IDLE -> HEADER.
REQ-014 SHALL: HEADER emit 14 bytes in order: dest_mac[47:40]..[7:0], src_mac[47:40]..[7:0], type[15:8], type[7:0]; tuser=0, tlast=0.
REQ-015 SHALL: first header byte valid on m_axis the cycle after header accept (latency 1).
REQ-016 SHALL: HEADER -> PAYLOAD once byte 13 is loaded into the output stage; header counter advances only when output stage accepts a byte.
REQ-017 SHALL: PAYLOAD: s_eth_payload_axis_tready = output stage can accept; tdata/tlast/tuser pass unchanged; input tlast -> IDLE.
REQ-018 SHALL: output stage be a two-register skid buffer (output reg + temp reg): 1 byte/cycle sustained under continuous m_axis_tready; no upstream tready combinationally from m_axis_tready.
REQ-019 SHALL: m_axis_tdata/tlast/tuser hold stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-020 SHALL: 16-bit frame byte counter, cleared on header accept, incremented per byte loaded into output stage.
REQ-021 SHALL: when loaded byte is number MAX_FRAME_LEN and input tlast=0: force tlast=1, tuser=1, pulse error_oversize, -> DROP.
REQ-022 SHALL: input tlast exactly at byte MAX_FRAME_LEN pass normally, no error.
REQ-023 SHALL: DROP: payload tready=1, bytes discarded, nothing emitted; on tlast -> IDLE.
REQ-024 SHALL: next header not accepted until state IDLE; header may be accepted while previous last byte still in output stage (back-to-back frames, no idle gap mandatory).
REQ-025 SHALL: payload tvalid in IDLE/HEADER ignored (tready=0).

Reset
REQ-026 SHALL: on tx_rst: state IDLE, counters 0, s_eth_hdr_ready=0, payload tready=0, m_axis_tvalid/tlast/tuser=0, m_axis_tdata=0, busy=0, error_oversize=0, skid regs empty.
REQ-027 SHALL: s_eth_hdr_ready rise first cycle after tx_rst deasserts.
REQ-028 SHALL: reset mid-frame abandon frame; no further output bytes; no tlast emitted.

Verification
REQ-029 SHALL: dest=01:02:03:04:05:06, src=0A:0B:0C:0D:0E:0F, type=0x0800, payload 46 bytes 0x00..0x2D, tready=1 -> 60 bytes contiguous, bytes 0..13 = 01..06,0A..0F,08,00, tlast on byte 59 only, tuser=0.
REQ-030 SHALL: same frame, m_axis_tready random 50% -> identical byte sequence, no drop/duplicate, outputs stable under stall.
REQ-031 SHALL: MAX_FRAME_LEN=64, 100-byte payload -> 64 bytes out, byte 63 tlast=1 tuser=1, one error_oversize pulse, remaining 50 bytes consumed, next frame correct.
REQ-032 SHALL: MAX_FRAME_LEN=64, 50-byte payload -> 64 bytes out, no error.
REQ-033 SHALL: payload tuser=1 on last byte -> output last byte tuser=1, no error_oversize.
REQ-034 SHALL: tx_rst asserted during header byte 5 -> m_axis_tvalid=0 next edge, hdr_ready=1 one cycle after release, following frame fully correct.
